// File: rtl/mask_rng_pkg.sv
// Shared definitions for the masked-ALU randomness source.
// Holds the fill/ready state encoding, the LFSR feedback polynomial, the
// default reset seed and the single-step LFSR function used both by the
// LFSR register and by the buffer write path.
package mask_rng_pkg;

    localparam int          LFSR_W             = 32;
    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY          = 32'h80200003;
    localparam logic [31:0] DEFAULT_RESET_SEED = 32'h6A09E667;

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } rng_state_t;

    // One Galois step: shift right, fold the polynomial in when a one falls out.
    // A nonzero state can never step to zero, so only loads need repairing.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
    endfunction

endpackage

// File: rtl/mask_rng_lfsr.sv
// LFSR state register for the mask randomness source.
// Ports:
//   g_clk       clock, rising edge
//   g_resetn    asynchronous active-low reset, returns the state to RESET_SEED
//   step        advance the LFSR by one Galois step
//   load        replace the state with load_value (zero is repaired to RESET_SEED)
//   load_value  word to load, normally the current state mixed with a seed
//   value       current LFSR state
module mask_rng_lfsr
    import mask_rng_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = DEFAULT_RESET_SEED
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] value
);

    // A zero state would lock the LFSR at zero forever, so a load that would
    // produce zero falls back to the reset seed instead.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            value <= RESET_SEED;
        end else if (load) begin
            value <= (load_value == 32'h0) ? RESET_SEED : load_value;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/mask_rng_source.sv
// Randomness source feeding the masked bitwise/boolean ALU.
// Keeps a Galois LFSR and a buffer of NWORDS mask words presented on z0..z5.
// The buffer is refilled one word per cycle after reset, prng_update, a seed
// injection or a flush; rng_ready marks a complete fresh set.
// Optional feature: define MASK_RNG_BYPASS_EN to add dbg_zero_masks, which
// forces z0..z5 to zero without disturbing the LFSR, buffer or rng_ready.
// Ports:
//   g_clk          clock, rising edge
//   g_resetn       asynchronous active-low reset
//   dbg_zero_masks (MASK_RNG_BYPASS_EN only) force the mask outputs to zero
//   flush          abandon current masks and restart the fill, LFSR kept
//   prng_update    masks consumed, request a full refill
//   seed_valid     seed word offered
//   seed           entropy word xor-ed into the LFSR
//   seed_ready     seed taken when seed_valid && seed_ready
//   rng_ready      z0..z5 hold a complete fresh set
//   z0..z5         mask words buffer[0]..buffer[5]
module mask_rng_source
    import mask_rng_pkg::*;
#(
    parameter int          XLEN       = LFSR_W,
    parameter int          NWORDS     = 6,
    parameter logic [31:0] RESET_SEED = DEFAULT_RESET_SEED
) (
    input  logic            g_clk,
    input  logic            g_resetn,
`ifdef MASK_RNG_BYPASS_EN
    input  logic            dbg_zero_masks,
`endif
    input  logic            flush,
    input  logic            prng_update,
    input  logic            seed_valid,
    input  logic [XLEN-1:0] seed,
    output logic            seed_ready,
    output logic            rng_ready,
    output logic [XLEN-1:0] z0,
    output logic [XLEN-1:0] z1,
    output logic [XLEN-1:0] z2,
    output logic [XLEN-1:0] z3,
    output logic [XLEN-1:0] z4,
    output logic [XLEN-1:0] z5
);

    localparam int              CNT_W    = $clog2(NWORDS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    rng_state_t       state;
    rng_state_t       state_next;
    logic [CNT_W-1:0] fill_cnt;
    logic [XLEN-1:0]  buffer [NWORDS];
    logic [XLEN-1:0]  lfsr_value;
    logic [XLEN-1:0]  lfsr_nxt;
    logic             lfsr_step;
    logic             lfsr_load;
    logic             buf_we;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             force_zero;

    mask_rng_lfsr #(
        .RESET_SEED (RESET_SEED)
    ) u_lfsr (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .step       (lfsr_step),
        .load       (lfsr_load),
        .load_value (lfsr_value ^ seed),
        .value      (lfsr_value)
    );

    // The buffer captures the same value the LFSR steps to, so after a fill
    // z5 always equals the LFSR state.
    assign lfsr_nxt = lfsr_next(lfsr_value);

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Flush overrides everything and does not step the LFSR, so the sequence
    // resumes without skipping or repeating. A seed beats prng_update; both
    // lead to the same single refill.
    always_comb begin
        state_next = state;
        lfsr_step  = 1'b0;
        lfsr_load  = 1'b0;
        buf_we     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        if (flush) begin
            state_next = FILL;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                FILL: begin
                    lfsr_step = 1'b1;
                    buf_we    = 1'b1;
                    if (fill_cnt == LAST_IDX) begin
                        state_next = READY;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                READY: begin
                    if (seed_valid) begin
                        lfsr_load  = 1'b1;
                        state_next = FILL;
                        cnt_clr    = 1'b1;
                    end else if (prng_update) begin
                        state_next = FILL;
                        cnt_clr    = 1'b1;
                    end
                end
                default: begin
                    state_next = FILL;
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    // Words not yet rewritten during a refill deliberately keep their old value.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            fill_cnt <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            if (buf_we) begin
                buffer[fill_cnt] <= lfsr_nxt;
            end
            if (cnt_clr) begin
                fill_cnt <= '0;
            end else if (cnt_inc) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // seed_ready drops while flush is high so the handshake never reports a
    // seed that the flush priority would discard.
    assign rng_ready  = (state == READY);
    assign seed_ready = (state == READY) && !flush;

`ifdef MASK_RNG_BYPASS_EN
    assign force_zero = dbg_zero_masks;
`else
    assign force_zero = 1'b0;
`endif

    assign z0 = force_zero ? '0 : buffer[0];
    assign z1 = force_zero ? '0 : buffer[1];
    assign z2 = force_zero ? '0 : buffer[2];
    assign z3 = force_zero ? '0 : buffer[3];
    assign z4 = force_zero ? '0 : buffer[4];
    assign z5 = force_zero ? '0 : buffer[5];

endmodule

// File: tb/tb_mask_rng_source.sv
// Self-checking bench for mask_rng_source. Expected mask sets are queued when
// stimulus is issued; a monitor pops and compares one set on every rising
// edge of rng_ready. Directed checks cover reset, fill timing, seed handling,
// flush priority and reset mid-fill. Define MASK_RNG_BYPASS_EN to also cover
// the zero-mask debug bypass.
module tb_mask_rng_source;

    typedef logic [5:0][31:0] word_set_t;

    localparam logic [31:0] SEED0 = 32'h6A09E667;

    logic        g_clk = 1'b0;
    logic        g_resetn;
`ifdef MASK_RNG_BYPASS_EN
    logic        dbg_zero_masks;
`endif
    logic        flush;
    logic        prng_update;
    logic        seed_valid;
    logic [31:0] seed;
    logic        seed_ready;
    logic        rng_ready;
    logic [31:0] z [6];

    int          checks = 0;
    int          errors = 0;
    word_set_t   exp_q [$];
    logic [31:0] model_lfsr;
    word_set_t   cur_set;
    word_set_t   old_set;
    logic        prev_ready = 1'b0;

    mask_rng_source dut (
        .g_clk          (g_clk),
        .g_resetn       (g_resetn),
`ifdef MASK_RNG_BYPASS_EN
        .dbg_zero_masks (dbg_zero_masks),
`endif
        .flush          (flush),
        .prng_update    (prng_update),
        .seed_valid     (seed_valid),
        .seed           (seed),
        .seed_ready     (seed_ready),
        .rng_ready      (rng_ready),
        .z0             (z[0]),
        .z1             (z[1]),
        .z2             (z[2]),
        .z3             (z[3]),
        .z4             (z[4]),
        .z5             (z[5])
    );

    always #5 g_clk = ~g_clk;

    function automatic logic [31:0] step(input logic [31:0] x);
        logic [31:0] y;
        y = {1'b0, x[31:1]};
        if (x[0]) y = y ^ 32'h80200003;
        return y;
    endfunction

    function automatic word_set_t expect_fill(input logic [31:0] start);
        word_set_t   s;
        logic [31:0] cur;
        cur = start;
        for (int i = 0; i < 6; i++) begin
            cur  = step(cur);
            s[i] = cur;
        end
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs from a negedge, clear them on the next negedge.
    task automatic applyStimulus(input logic fl, input logic pu, input logic sv,
                                 input logic [31:0] sd);
        flush       = fl;
        prng_update = pu;
        seed_valid  = sv;
        seed        = sd;
        @(negedge g_clk);
        flush       = 1'b0;
        prng_update = 1'b0;
        seed_valid  = 1'b0;
        seed        = 32'h0;
    endtask

    task automatic waitReady(input int expected_cycles);
        int n    = 0;
        int leak = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge g_clk);
            if (rng_ready) begin
                n = i;
                break;
            end
            if (seed_ready) leak++;
        end
        if (n == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: rng_ready still 0 after 40 cycles, expected rise after %0d",
                     expected_cycles);
        end else begin
            checkOutput("fill_cycles", n, expected_cycles);
        end
        checkOutput("seed_ready_during_fill", leak, 0);
    endtask

    // Scoreboard monitor: one expected set per rising edge of rng_ready.
    always @(negedge g_clk) begin
        if (rng_ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_set: rng_ready rose, expected no new set");
            end else begin
                word_set_t e;
                e = exp_q.pop_front();
                for (int i = 0; i < 6; i++) begin
                    checks++;
                    if (z[i] !== e[i]) begin
                        errors++;
                        $display("[TB] FAIL z%0d: got %h, expected %h", i, z[i], e[i]);
                    end
                end
            end
        end
        prev_ready = rng_ready;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        g_resetn    = 1'b0;
`ifdef MASK_RNG_BYPASS_EN
        dbg_zero_masks = 1'b0;
`endif
        flush       = 1'b0;
        prng_update = 1'b0;
        seed_valid  = 1'b0;
        seed        = 32'h0;

        // Reset values
        repeat (2) @(negedge g_clk);
        checkOutput("reset_rng_ready", rng_ready, 1'b0);
        checkOutput("reset_seed_ready", seed_ready, 1'b0);
        checkOutput("reset_z0", z[0], 32'h0);
        checkOutput("reset_z5", z[5], 32'h0);

        // First fill from the reset seed: z0/z1 hand-computed
        cur_set    = expect_fill(32'h5A927998);
        cur_set    = {cur_set[3:0], 32'h5A927998, 32'hB524F330};
        model_lfsr = cur_set[5];
        exp_q.push_back(cur_set);
        g_resetn = 1'b1;
        waitReady(6);
        checkOutput("first_z0_const", z[0], 32'hB524F330);
        checkOutput("first_z1_const", z[1], 32'h5A927998);
        checkOutput("ready_seed_ready", seed_ready, 1'b1);

        // prng_update refill: new z0 steps from old z5
        old_set    = cur_set;
        cur_set    = expect_fill(model_lfsr);
        model_lfsr = cur_set[5];
        exp_q.push_back(cur_set);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("update_ready_drop", rng_ready, 1'b0);
        @(negedge g_clk);
        checkOutput("partial_new_z0", z[0], step(old_set[5]));
        checkOutput("partial_old_z5", z[5], old_set[5]);
        waitReady(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (z[i] === z[i+1]) begin
                errors++;
                $display("[TB] FAIL distinct_z%0d: got equal %h, expected differing words", i, z[i]);
            end
        end

        // Seed equal to the LFSR state: xor is zero, repaired to the reset seed
        checkOutput("seed_ready_before_seed", seed_ready, 1'b1);
        cur_set    = expect_fill(SEED0);
        model_lfsr = cur_set[5];
        exp_q.push_back(cur_set);
        applyStimulus(1'b0, 1'b0, 1'b1, z[5] === old_set[5] ? 32'h0 : expect_fill(old_set[5])[5]);
        waitReady(6);
        checkOutput("repair_z0_const", z[0], 32'hB524F330);

        // flush on the third FILL cycle: two words written, then a full restart
        cur_set    = expect_fill(step(step(model_lfsr)));
        model_lfsr = cur_set[5];
        exp_q.push_back(cur_set);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge g_clk);
        @(negedge g_clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("flush_ready_low", rng_ready, 1'b0);
        waitReady(6);

        // flush + seed + prng_update together: flush wins, seed ignored;
        // a seed offered during FILL is also ignored
        cur_set    = expect_fill(model_lfsr);
        model_lfsr = cur_set[5];
        exp_q.push_back(cur_set);
        flush       = 1'b1;
        prng_update = 1'b1;
        seed_valid  = 1'b1;
        seed        = 32'h12345678;
        #1;
        checkOutput("seed_ready_under_flush", seed_ready, 1'b0);
        @(negedge g_clk);
        flush       = 1'b0;
        prng_update = 1'b0;
        seed_valid  = 1'b1;
        seed        = 32'hDEADBEEF;
        #1;
        checkOutput("seed_ready_in_fill", seed_ready, 1'b0);
        @(negedge g_clk);
        seed_valid  = 1'b0;
        seed        = 32'h0;
        waitReady(5);

        // Reset in the middle of a fill: immediate return, then a fresh first set
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge g_clk);
        @(negedge g_clk);
        g_resetn = 1'b0;
        #1;
        checkOutput("midfill_reset_z0", z[0], 32'h0);
        checkOutput("midfill_reset_ready", rng_ready, 1'b0);
        @(negedge g_clk);
        cur_set    = expect_fill(SEED0);
        model_lfsr = cur_set[5];
        exp_q.push_back(cur_set);
        g_resetn = 1'b1;
        waitReady(6);
        checkOutput("midfill_restart_z1", z[1], 32'h5A927998);

`ifdef MASK_RNG_BYPASS_EN
        // Bypass: outputs forced to zero, refill and rng_ready unaffected
        dbg_zero_masks = 1'b1;
        #1;
        checkOutput("bypass_z0_zero", z[0], 32'h0);
        checkOutput("bypass_ready_kept", rng_ready, 1'b1);
        cur_set    = expect_fill(model_lfsr);
        model_lfsr = cur_set[5];
        exp_q.push_back('0);
        @(negedge g_clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("bypass_ready_drop", rng_ready, 1'b0);
        waitReady(6);
        dbg_zero_masks = 1'b0;
        #1;
        checkOutput("bypass_release_z0", z[0], cur_set[0]);
        checkOutput("bypass_release_z5", z[5], cur_set[5]);
`endif

        repeat (3) @(negedge g_clk);
        checkOutput("scoreboard_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
